sar_adc_ctrl: RTL and testbench



---
 rtl/sar_adc_pkg.sv | 20 ++
 rtl/sar_adc_cmp.sv | 19 +
 rtl/sar_adc_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/sar_adc_pkg.sv
// Shared state encoding and trial-voltage helper for the SAR ADC receiver.
package sar_adc_pkg;

  localparam int MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAMPLE  = 2'd1,
    CONVERT = 2'd2,
    DONE    = 2'd3
  } state_t;

  // DAC-equivalent voltage for a trial code: code * vref / 2**width.
  function automatic real trial_voltage(input logic [MAX_WIDTH-1:0] code,
                                        input int                   width,
                                        input real                  vref);
    return real'(code) * vref / real'(32'd1 << width);
  endfunction

endpackage

// File: rtl/sar_adc_cmp.sv
// Analog-facing comparator of the SAR loop; kept separate so offset or
// hysteresis can be modelled later without touching the controller.
module sar_adc_cmp (
  input  real  vin_held,
  input  real  vtrial,
  output logic ge
);

  // Ideal comparison of the held sample against the trial voltage.
  always_comb begin
    ge = 1'b0;
    if (vin_held >= vtrial) begin
      ge = 1'b1;
    end else begin
      ge = 1'b0;
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation receiver: samples a real voltage and returns a code.
// Optional overrange flag port ovr is built when SAR_ADC_CTRL_OVERRANGE_EN is defined.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int  WIDTH = 8,
  parameter real VREF  = 2.5
) (
  input  logic             clk,
  input  logic             rst,
  input  real              vin,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] code
`ifdef SAR_ADC_CTRL_OVERRANGE_EN
  ,
  output logic             ovr
`endif
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1'b1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [WIDTH-1:0] TRIAL_MSB = {1'b1, {(WIDTH-1){1'b0}}};

  state_t               state_r;
  state_t               state_s;
  logic [WIDTH-1:0]     trial_r;
  logic [WIDTH-1:0]     trial_s;
  logic [WIDTH-1:0]     keep_s;
  logic [WIDTH-1:0]     code_r;
  logic [WIDTH-1:0]     code_s;
  logic [IDX_W-1:0]     idx_r;
  logic [IDX_W-1:0]     idx_s;
  logic [IDX_W-1:0]     idx_dec_s;
  logic                 busy_r;
  logic                 busy_s;
  logic                 done_r;
  logic                 done_s;
  logic                 load_s;
  logic                 ge_s;
  logic [MAX_WIDTH-1:0] trial_ext_s;
  real                  vin_held_r;
  real                  vtrial_s;

  assign trial_ext_s = MAX_WIDTH'(trial_r);
  assign vtrial_s    = trial_voltage(trial_ext_s, WIDTH, VREF);
  assign idx_dec_s   = idx_r - IDX_ONE;

  sar_adc_cmp u_cmp (
    .vin_held (vin_held_r),
    .vtrial   (vtrial_s),
    .ge       (ge_s)
  );

  // Next state, bit decision and registered-output decode.
  always_comb begin
    state_s = state_r;
    trial_s = trial_r;
    idx_s   = idx_r;
    code_s  = code_r;
    keep_s  = trial_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SAMPLE;
        end else begin
          state_s = IDLE;
        end
      end
      SAMPLE: begin
        trial_s = TRIAL_MSB;
        idx_s   = IDX_TOP;
        state_s = CONVERT;
      end
      CONVERT: begin
        if (ge_s) begin
          keep_s[idx_r] = 1'b1;
        end else begin
          keep_s[idx_r] = 1'b0;
        end
        if (idx_r == IDX_ZERO) begin
          trial_s = keep_s;
          code_s  = keep_s;
          load_s  = 1'b1;
          state_s = DONE;
        end else begin
          keep_s[idx_dec_s] = 1'b1;
          trial_s = keep_s;
          idx_s   = idx_dec_s;
          state_s = CONVERT;
        end
      end
      DONE: begin
        if (start) begin
          state_s = SAMPLE;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s == SAMPLE) || (state_s == CONVERT);
    done_s = (state_s == DONE);
  end

  // FSM state, SAR trial/index and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      trial_r <= {WIDTH{1'b0}};
      idx_r   <= IDX_ZERO;
      code_r  <= {WIDTH{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      trial_r <= trial_s;
      idx_r   <= idx_s;
      code_r  <= code_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  // Track-and-hold: vin is captured only while sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vin_held_r <= 0.0;
    end else if (state_r == SAMPLE) begin
      vin_held_r <= vin;
    end else begin
      vin_held_r <= vin_held_r;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign code = code_r;

`ifdef SAR_ADC_CTRL_OVERRANGE_EN
  logic ovr_r;
  logic ovr_s;

  assign ovr_s = (vin_held_r < 0.0) || (vin_held_r >= VREF);

  // Overrange flag, updated on the same edge as code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovr_r <= 1'b0;
    end else if (load_s) begin
      ovr_r <= ovr_s;
    end else begin
      ovr_r <= ovr_r;
    end
  end

  assign ovr = ovr_r;
`endif

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Scoreboard bench for sar_adc_ctrl: a driver queues expected codes from an
// ideal quantiser model; a monitor checks each done pulse against the queue.
module tb_sar_adc_ctrl;

  localparam int  WIDTH = 8;
  localparam real VREF  = 2.5;
  localparam int  LAT   = WIDTH + 1;

  logic             clk = 1'b0;
  logic             rst;
  real              vin;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] code;
`ifdef SAR_ADC_CTRL_OVERRANGE_EN
  logic             ovr;
`endif

  typedef struct {
    int   code;
    logic ovr;
    int   due;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;

  sar_adc_ctrl #(.WIDTH(WIDTH), .VREF(VREF)) dut (
    .clk   (clk),
    .rst   (rst),
    .vin   (vin),
    .start (start),
    .busy  (busy),
    .done  (done),
    .code  (code)
`ifdef SAR_ADC_CTRL_OVERRANGE_EN
    ,
    .ovr   (ovr)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Ideal quantiser: floor(v / VREF * 2**WIDTH) clamped to the code range.
  function automatic int ref_code(input real v);
    real x;
    int  top;
    top = (1 << WIDTH) - 1;
    x   = $floor(v / VREF * real'(1 << WIDTH));
    if (x < 0.0) return 0;
    if (x > real'(top)) return top;
    return int'(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      busy_cnt = 0;
    end else if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("code", 32'(code), 32'(e.code));
        chk("latency", 32'(cyc), 32'(e.due));
        chk("busy_cycles", 32'(busy_cnt), 32'(LAT));
`ifdef SAR_ADC_CTRL_OVERRANGE_EN
        chk("ovr", 32'(ovr), 32'(e.ovr));
`endif
      end
      busy_cnt = 0;
    end else if (busy) begin
      busy_cnt++;
    end
  end

  // Pulses start for one cycle; DUT must be in IDLE or DONE.
  task automatic issue(input real v);
    exp_t e;
    vin     = v;
    start   = 1'b1;
    e.code  = ref_code(v);
    e.ovr   = (v < 0.0) || (v >= VREF);
    e.due   = cyc + 1 + LAT;
    exp_q.push_back(e);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int  d0;
    int  base;
    int  kind;
    real v;
    exp_t e;

    rst   = 1'b1;
    start = 1'b0;
    vin   = 0.0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_code", 32'(code), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue(2.0);
    wait_drain();
    issue(0.0);
    wait_drain();
    issue(1.25);
    wait_drain();
    issue(2.49);
    wait_drain();

    // Input changes after sampling and start while busy must both be ignored.
    d0 = done_cnt;
    issue(2.0);
    @(posedge clk);
    #1 vin = 0.5;
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_drain();
    repeat (2 * LAT + 4) @(posedge clk);
    #1;
    chk("single_done", 32'(done_cnt - d0), 32'd1);

    // start held high: back-to-back conversions every LAT+1 cycles.
    vin   = 1.25;
    start = 1'b1;
    base  = cyc + 1;
    for (int k = 0; k < 3; k++) begin
      e.code = 128;
      e.ovr  = 1'b0;
      e.due  = base + LAT + k * (LAT + 1);
      exp_q.push_back(e);
    end
    while (cyc < base + 2 * (LAT + 1) + LAT) @(posedge clk);
    #1 start = 1'b0;
    wait_drain();

    // Asynchronous reset in the middle of a conversion.
    issue(2.0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_done", 32'(done), 32'd0);
    chk("async_rst_code", 32'(code), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    issue(2.0);
    wait_drain();

    issue(2.5);
    wait_drain();
    issue(-0.1);
    wait_drain();
    issue(2.0);
    wait_drain();

    for (int i = 0; i < 24; i++) begin
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        v = -real'($urandom_range(1, 1000)) / 1000.0;
      end else if (kind == 1) begin
        v = VREF + real'($urandom_range(0, 1000)) / 1000.0;
      end else begin
        v = (real'($urandom_range(0, (1 << WIDTH) - 1)) + 0.1 +
             0.8 * real'($urandom_range(0, 1000)) / 1000.0) * VREF / real'(1 << WIDTH);
      end
      issue(v);
      wait_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
